// File: rtl/tpu_pkg.sv
// Shared configuration for the accumulator-table drain: array geometry,
// derived address widths and the drain FSM state encoding.
package tpu_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int MAX_OUT_ROWS = 128;
  localparam int MAX_OUT_COLS = 128;
  localparam int SYS_ARR_ROWS = 16;
  localparam int SYS_ARR_COLS = 16;

  localparam int NUM_SUBMATS_M = MAX_OUT_ROWS / SYS_ARR_ROWS;
  localparam int NUM_SUBMATS_N = MAX_OUT_COLS / SYS_ARR_COLS;

  localparam int SUBMAT_M_W = $clog2(NUM_SUBMATS_M);
  localparam int SUBMAT_N_W = $clog2(NUM_SUBMATS_N);
  localparam int SUB_ROW_W  = $clog2(SYS_ARR_ROWS);
  localparam int OUT_ROW_W  = $clog2(MAX_OUT_ROWS);
  localparam int NUM_M_W    = SUBMAT_M_W + 1;
  localparam int NUM_N_W    = SUBMAT_N_W + 1;
  localparam int ROW_BITS   = DATA_WIDTH * SYS_ARR_COLS;

  typedef enum logic [1:0] {
    DRAIN_IDLE  = 2'd0,
    DRAIN_ISSUE = 2'd1,
    DRAIN_FLUSH = 2'd2,
    DRAIN_DONE  = 2'd3
  } drain_state_e;

endpackage

// File: rtl/accum_drain_fifo.sv
// Two-entry FIFO holding returned table rows plus their tag. A push into a
// full FIFO is accepted only when a pop happens in the same cycle.
module accum_drain_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/accum_table_drain.sv
// Walks num_m x num_n output submatrices row by row, reads each table row and
// streams it out with its global row / column block. Handshake: a row moves
// when out_valid && out_ready; out_* hold steady while out_valid && !out_ready.
module accum_table_drain
  import tpu_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_M_W-1:0]      num_m,
  input  logic [NUM_N_W-1:0]      num_n,
  output logic                    busy,
  output logic                    done,
  output logic [SYS_ARR_COLS-1:0] rd_en,
  output logic [SUBMAT_M_W-1:0]   submat_m,
  output logic [SUBMAT_N_W-1:0]   submat_n,
  output logic [SUB_ROW_W-1:0]    sub_row,
  input  logic [ROW_BITS-1:0]     rd_data,
  output logic [ROW_BITS-1:0]     out_data,
  output logic [OUT_ROW_W-1:0]    out_row,
  output logic [SUBMAT_N_W-1:0]   out_col_blk,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output drain_state_e            state_dbg
);

  localparam int TAG_W   = OUT_ROW_W + SUBMAT_N_W + 1;
  localparam int ENTRY_W = ROW_BITS + TAG_W;

  drain_state_e          state_q, state_d;
  logic [SUBMAT_M_W-1:0] m_q, m_d;
  logic [SUBMAT_N_W-1:0] n_q, n_d;
  logic [SUB_ROW_W-1:0]  r_q, r_d;
  logic [NUM_M_W-1:0]    num_m_q, num_m_d;
  logic [NUM_N_W-1:0]    num_n_q, num_n_d;
  logic                  inflight_q, inflight_d;
  logic [TAG_W-1:0]      tag_q, tag_d;

  logic                  last_m, last_n, last_r, last_read;
  logic                  issue, room, pop_fire, flush_clear, head_last;
  logic [2:0]            occupancy;
  logic [OUT_ROW_W-1:0]  row_idx;
  logic                  fifo_full, fifo_empty;
  logic [1:0]            fifo_count;
  logic [ENTRY_W-1:0]    fifo_dout;

  assign last_m    = ({1'b0, m_q} == num_m_q - NUM_M_W'(1));
  assign last_n    = ({1'b0, n_q} == num_n_q - NUM_N_W'(1));
  assign last_r    = (r_q == SUB_ROW_W'(SYS_ARR_ROWS - 1));
  assign last_read = last_m && last_r && last_n;
  assign row_idx   = OUT_ROW_W'(m_q) * OUT_ROW_W'(SYS_ARR_ROWS) + OUT_ROW_W'(r_q);

  // A row popped this cycle frees its slot, so the budget counts it as gone;
  // this keeps fifo + in-flight <= 2 and still allows one row per cycle.
  assign pop_fire    = !fifo_empty && out_ready;
  assign occupancy   = 3'(fifo_count) + 3'(inflight_q) - 3'(pop_fire);
  assign room        = (occupancy < 3'd2);
  assign issue       = (state_q == DRAIN_ISSUE) && room;
  assign flush_clear = !inflight_q && (fifo_empty || (fifo_count == 2'd1 && out_ready));

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    n_d        = n_q;
    r_d        = r_q;
    num_m_d    = num_m_q;
    num_n_d    = num_n_q;
    inflight_d = issue;
    tag_d      = {row_idx, n_q, last_read};
    case (state_q)
      DRAIN_IDLE: begin
        if (start) begin
          num_m_d = num_m;
          num_n_d = num_n;
          m_d     = '0;
          n_d     = '0;
          r_d     = '0;
          state_d = (num_m == '0 || num_n == '0) ? DRAIN_DONE : DRAIN_ISSUE;
        end
      end
      DRAIN_ISSUE: begin
        if (issue) begin
          if (last_read) begin
            state_d = DRAIN_FLUSH;
            m_d     = '0;
            n_d     = '0;
            r_d     = '0;
          end else if (!last_n) begin
            n_d = n_q + SUBMAT_N_W'(1);
          end else begin
            n_d = '0;
            if (!last_r) begin
              r_d = r_q + SUB_ROW_W'(1);
            end else begin
              r_d = '0;
              m_d = m_q + SUBMAT_M_W'(1);
            end
          end
        end
      end
      DRAIN_FLUSH: if (flush_clear) state_d = DRAIN_DONE;
      DRAIN_DONE:  state_d = DRAIN_IDLE;
      default:     state_d = DRAIN_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= DRAIN_IDLE;
      m_q        <= '0;
      n_q        <= '0;
      r_q        <= '0;
      num_m_q    <= '0;
      num_n_q    <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      n_q        <= n_d;
      r_q        <= r_d;
      num_m_q    <= num_m_d;
      num_n_q    <= num_n_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

  accum_drain_fifo #(.WIDTH(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (inflight_q),
    .din   ({rd_data, tag_q}),
    .pop   (out_ready),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {out_data, out_row, out_col_blk, head_last} = fifo_dout;
  assign out_last  = head_last && !fifo_empty;
  assign out_valid = !fifo_empty;
  assign busy      = (state_q == DRAIN_ISSUE) || (state_q == DRAIN_FLUSH);
  assign done      = (state_q == DRAIN_DONE);
  assign rd_en     = {SYS_ARR_COLS{issue}};
  assign submat_m  = m_q;
  assign submat_n  = n_q;
  assign sub_row   = r_q;
  assign state_dbg = state_q;

endmodule
